onchip_mem_arbiter: RTL and testbench
=====================================

// Module: onchip_mem_arbiter
// PURPOSE
//  Two-requester Avalon-MM arbiter that shares one single-port on-chip RAM (32-bit, byte-enabled,
//  1-cycle read latency: address registered, output unregistered) between a streaming master
//  (port A, e.g. frame writer) and a control master (port B, e.g. CPU). Round-robin fair,
//  one command accepted per cycle, read data returned in order to its owner, range-checked.
// PARAMETERS
//  ADDR_W   15     word address width of RAM and both requester ports
//  DATA_W   32     data width; byteenable width = DATA_W/8
//  DEPTH    25000  implemented words; addresses >= DEPTH are out of range
// PORTS
//  clk              in   1       system clock
//  reset            in   1       asynchronous, active-high reset
//  a_address        in   ADDR_W  port A word address
//  a_byteenable     in   DATA_W/8
//  a_read / a_write in   1       port A command strobes (both high = protocol error, treated as write)
//  a_writedata      in   DATA_W
//  a_waitrequest    out  1       high = command not accepted this cycle
//  a_readdata       out  DATA_W
//  a_readdatavalid  out  1
//  b_*              --   --      identical set for port B
//  mem_address      out  ADDR_W  to RAM
//  mem_byteenable   out  DATA_W/8
//  mem_chipselect   out  1
//  mem_write        out  1
//  mem_writedata    out  DATA_W
//  mem_clken        out  1       constant 1 out of reset
//  mem_reset_req    out  1       high while reset asserted, 0 otherwise
//  mem_readdata     in   DATA_W  valid the cycle after a read command is issued
//  range_err        out  1       sticky; cleared only by reset
//  range_err_addr   out  ADDR_W  address of first out-of-range access
// BEHAVIOUR
//  Reset (async assert, sync deassert use): a/b_waitrequest=1, a/b_readdatavalid=0, readdata=0,
//   mem_chipselect=0, mem_write=0, rr_last=B (so A wins first tie), rd_pend=0, range_err=0, err_addr=0.
//  Arbitration (combinational each cycle, out of reset):
//   - req_x = x_read|x_write. Only one requester -> it wins. Both -> the one not equal to rr_last wins.
//   - Winner: waitrequest=0; loser: waitrequest=1 and must hold its command. No requester: both waitrequest=0.
//   - rr_last updates to winner at clock edge when a command is accepted; unchanged otherwise.
//  Issue: winner's address/byteenable/writedata drive mem_* combinationally; mem_chipselect=1.
//   - Write: mem_write=1; complete on the accept edge; no response.
//   - Read: mem_write=0; registers rd_pend=1, rd_owner=winner.
//  Response: cycle after read accept, readdatavalid=1 for rd_owner only, readdata=mem_readdata
//   (registered output: data appears on the owner port the cycle after mem_readdata is valid,
//   i.e. read latency = 2 cycles from accept). Back-to-back reads: one per cycle, full throughput.
//  Range check: address >= DEPTH -> command is accepted (waitrequest=0) but mem_chipselect=0;
//   write dropped; read still returns readdatavalid with readdata=0 at normal latency.
//   First such event sets range_err and captures range_err_addr; later events do not overwrite.
//  Simultaneous: read response for one port and new accept for the other in the same cycle is legal.
//  Reset mid-read: pending response discarded, readdatavalid never asserted for it.
// TESTING
//  1 Reset released, A writes 0xDEADBEEF @0x0010 be=0xF, then A reads 0x0010 -> a_readdatavalid
//    2 cycles after read accept, a_readdata=0xDEADBEEF; b_readdatavalid stays 0.
//  2 Both A and B hold reads every cycle for 8 cycles -> grants alternate A,B,A,B...; 4 responses
//    each, in order, each to its own port, no bubbles.
//  3 Byte enables: write 0x11223344 be=0xF then 0xAABBCCDD be=0x5 same addr -> read 0x11BB33DD.
//  4 B writes addr 25000 data 0x12345678 -> accepted, mem_chipselect=0, range_err=1,
//    range_err_addr=25000; read 25000 -> readdata=0; later bad access at 30000 keeps err_addr=25000.
//  5 A reads, reset asserted next cycle -> no readdatavalid on either port, all outputs at reset values.
//  6 A write and B read same cycle, rr_last=A -> B accepted first, A waitrequest=1 one cycle then accepted.

Source files
------------

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM requester-side bundle: one command/response channel between a
// master and the shared-RAM arbiter.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM (registered address,
// unregistered data) between two Avalon-MM masters. One command per cycle,
// in-order read responses routed to their owner, sticky out-of-range capture.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 25000
) (
    input  logic                clk,
    input  logic                reset,
    onchip_mem_arbiter_if.slave a,
    onchip_mem_arbiter_if.slave b,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    output logic                mem_reset_req,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                range_err,
    output logic [ADDR_W-1:0]   range_err_addr
);

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    port_e rr_last, rr_next;

    logic req_a, req_b;
    logic grant_a, grant_b;

    logic                cmd_valid;
    logic                cmd_write;
    logic                cmd_oor;
    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W/8-1:0] sel_byteenable;
    logic [DATA_W-1:0]   sel_writedata;
    logic                a_wait, b_wait;

    logic                rd_pend;
    port_e               rd_owner;
    logic                rd_oor;

    logic                a_rdv_q, b_rdv_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;

    assign req_a = a.read | a.write;
    assign req_b = b.read | b.write;

    // Fairness state: remember the last port whose command was accepted.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_last <= PORT_B;
        else       rr_last <= rr_next;
    end

    // Grant decision and next round-robin pointer.
    // NOTE: every output gets a default before the branches so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (req_a && req_b) begin
                if (rr_last == PORT_B) grant_a = 1'b1;
                else                   grant_b = 1'b1;
            end else begin
                grant_a = req_a;
                grant_b = req_b;
            end
        end
        rr_next = rr_last;
        if (grant_a)      rr_next = PORT_A;
        else if (grant_b) rr_next = PORT_B;
    end

    // Steer the winner onto the RAM bus and stall only the losing requester.
    always_comb begin
        sel_address    = grant_b ? b.address    : a.address;
        sel_byteenable = grant_b ? b.byteenable : a.byteenable;
        sel_writedata  = grant_b ? b.writedata  : a.writedata;
        cmd_valid      = grant_a | grant_b;
        // A simultaneous read+write strobe is treated as a write.
        cmd_write      = grant_b ? b.write : a.write;
        cmd_oor        = ({1'b0, sel_address} >= DEPTH_L);
        mem_chipselect = cmd_valid & ~cmd_oor;
        mem_write      = cmd_valid & ~cmd_oor & cmd_write;
        a_wait         = reset | (req_a & ~grant_a);
        b_wait         = reset | (req_b & ~grant_b);
    end

    assign mem_address    = sel_address;
    assign mem_byteenable = sel_byteenable;
    assign mem_writedata  = sel_writedata;
    assign mem_clken      = 1'b1;
    assign mem_reset_req  = reset;

    // Track the read issued this cycle; RAM data for it is valid next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_A;
            rd_oor   <= 1'b0;
        end else begin
            rd_pend  <= cmd_valid & ~cmd_write;
            rd_owner <= grant_b ? PORT_B : PORT_A;
            rd_oor   <= cmd_oor;
        end
    end

    // Register RAM data onto the owning port; out-of-range reads return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rdv_q   <= 1'b0;
            b_rdv_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdv_q <= rd_pend & (rd_owner == PORT_A);
            b_rdv_q <= rd_pend & (rd_owner == PORT_B);
            if (rd_pend && rd_owner == PORT_A) a_rdata_q <= rd_oor ? '0 : mem_readdata;
            if (rd_pend && rd_owner == PORT_B) b_rdata_q <= rd_oor ? '0 : mem_readdata;
        end
    end

    // Capture only the first out-of-range accepted command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            range_err      <= 1'b0;
            range_err_addr <= '0;
        end else if (cmd_valid && cmd_oor && !range_err) begin
            range_err      <= 1'b1;
            range_err_addr <= sel_address;
        end
    end

    assign a.waitrequest   = a_wait;
    assign b.waitrequest   = b_wait;
    assign a.readdatavalid = a_rdv_q;
    assign b.readdatavalid = b_rdv_q;
    assign a.readdata      = a_rdata_q;
    assign b.readdata      = b_rdata_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural single-port RAM.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        mem_reset_req;
    logic [31:0] mem_readdata;
    logic        range_err;
    logic [14:0] range_err_addr;

    int checks = 0;
    int errors = 0;

    onchip_mem_arbiter_if #(.ADDR_W(15), .DATA_W(32)) a_if ();
    onchip_mem_arbiter_if #(.ADDR_W(15), .DATA_W(32)) b_if ();

    onchip_mem_arbiter #(.ADDR_W(15), .DATA_W(32), .DEPTH(25000)) dut (
        .clk            (clk),
        .reset          (reset),
        .a              (a_if),
        .b              (b_if),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_reset_req  (mem_reset_req),
        .mem_readdata   (mem_readdata),
        .range_err      (range_err),
        .range_err_addr (range_err_addr)
    );

    always #5 clk = ~clk;

    // RAM model: address registered on read, data combinational from it.
    logic [31:0] ram [0:32767];
    logic [14:0] ram_rd_addr;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int i = 0; i < 4; i++)
                    if (mem_byteenable[i]) ram[mem_address][i*8 +: 8] <= mem_writedata[i*8 +: 8];
            end else begin
                ram_rd_addr <= mem_address;
            end
        end
    end
    assign mem_readdata = ram[ram_rd_addr];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        a_if.read = 0; a_if.write = 0; a_if.address = '0; a_if.byteenable = '0; a_if.writedata = '0;
        b_if.read = 0; b_if.write = 0; b_if.address = '0; b_if.byteenable = '0; b_if.writedata = '0;
    endtask

    // Present one command and hold it until accepted; returns at accept edge + 1.
    task automatic issue(input bit port_b, input bit wr, input logic [14:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        bit done = 0;
        if (!port_b) begin
            a_if.address = addr; a_if.writedata = data; a_if.byteenable = be;
            a_if.read = !wr; a_if.write = wr;
        end else begin
            b_if.address = addr; b_if.writedata = data; b_if.byteenable = be;
            b_if.read = !wr; b_if.write = wr;
        end
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if ((port_b ? b_if.waitrequest : a_if.waitrequest) == 1'b0) done = 1;
            @(posedge clk); #1;
        end
        if (!port_b) begin a_if.read = 0; a_if.write = 0; end
        else         begin b_if.read = 0; b_if.write = 0; end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL issue_accept port_b=%0d actual=never_accepted required=accepted", port_b);
        end
    endtask

    // Issue a read and wait (bounded) for its response; lat counts cycles from accept.
    task automatic do_read(input bit port_b, input logic [14:0] addr,
                           output logic [31:0] data, output int lat, output bit stray);
        lat = 0; data = '0; stray = 0;
        issue(port_b, 1'b0, addr, 32'h0, 4'hF);
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (port_b ? b_if.readdatavalid : a_if.readdatavalid) begin
                lat  = n;
                data = port_b ? b_if.readdata : a_if.readdata;
            end
            if (port_b ? a_if.readdatavalid : b_if.readdatavalid) stray = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1; idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (a_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_a_wait actual=%b required=1", a_if.waitrequest); end
        checks++; if (b_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_b_wait actual=%b required=1", b_if.waitrequest); end
        checks++; if ({a_if.readdatavalid, b_if.readdatavalid} !== 2'b00) begin errors++; $display("FAIL rst_rdv actual=%b%b required=00", a_if.readdatavalid, b_if.readdatavalid); end
        checks++; if (a_if.readdata !== 32'h0 || b_if.readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata actual=%h/%h required=0", a_if.readdata, b_if.readdata); end
        checks++; if ({mem_chipselect, mem_write} !== 2'b00) begin errors++; $display("FAIL rst_mem actual=%b%b required=00", mem_chipselect, mem_write); end
        checks++; if ({range_err, range_err_addr} !== 16'h0) begin errors++; $display("FAIL rst_err actual=%b/%0d required=0/0", range_err, range_err_addr); end
        checks++; if ({mem_reset_req, mem_clken} !== 2'b11) begin errors++; $display("FAIL rst_memctl actual=%b%b required=11", mem_reset_req, mem_clken); end
        @(posedge clk); #1; reset = 0;
        @(negedge clk);
        checks++; if ({a_if.waitrequest, b_if.waitrequest} !== 2'b00) begin errors++; $display("FAIL idle_wait actual=%b%b required=00", a_if.waitrequest, b_if.waitrequest); end
        checks++; if ({mem_reset_req, mem_clken} !== 2'b01) begin errors++; $display("FAIL run_memctl actual=%b%b required=01", mem_reset_req, mem_clken); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] d; int lat; bit stray;
        a_if.address = 15'h0010; a_if.writedata = 32'hDEADBEEF; a_if.byteenable = 4'hF; a_if.write = 1;
        @(negedge clk);
        checks++; if (a_if.waitrequest !== 1'b0) begin errors++; $display("FAIL wr_a_wait actual=%b required=0", a_if.waitrequest); end
        checks++; if ({mem_chipselect, mem_write} !== 2'b11 || mem_address !== 15'h0010) begin errors++; $display("FAIL wr_issue actual=cs%b we%b addr%h required=cs1 we1 addr0010", mem_chipselect, mem_write, mem_address); end
        @(posedge clk); #1; a_if.write = 0;
        do_read(1'b0, 15'h0010, d, lat, stray);
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_a_data actual=%h required=deadbeef", d); end
        checks++; if (lat != 2) begin errors++; $display("FAIL rd_a_latency actual=%0d required=2", lat); end
        checks++; if (stray) begin errors++; $display("FAIL rd_b_stray actual=1 required=0"); end
    endtask

    task automatic test_back_to_back();
        int a_idx = 0, b_idx = 0;
        for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 15'h0040 + 15'(i), 32'hA0000000 + i, 4'hF);
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, 15'h0050 + 15'(i), 32'hB0000000 + i, 4'hF);
        // rr_last is now B, so A takes the first tie.
        a_if.address = 15'h0040; a_if.read = 1;
        b_if.address = 15'h0050; b_if.read = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 7) begin
                checks++;
                if (a_if.waitrequest !== 1'(k % 2) || b_if.waitrequest !== 1'(1 - k % 2)) begin
                    errors++; $display("FAIL b2b_grant cycle=%0d actual=wa%b wb%b required=wa%0d wb%0d", k, a_if.waitrequest, b_if.waitrequest, k % 2, 1 - k % 2);
                end
            end
            checks++;
            if (a_if.readdatavalid !== 1'(k >= 2 && k % 2 == 0) || b_if.readdatavalid !== 1'(k >= 3 && k % 2 == 1)) begin
                errors++; $display("FAIL b2b_rdv cycle=%0d actual=a%b b%b", k, a_if.readdatavalid, b_if.readdatavalid);
            end
            if (k >= 2 && k % 2 == 0) begin
                checks++;
                if (a_if.readdata !== 32'hA0000000 + (k - 2) / 2) begin errors++; $display("FAIL b2b_a_data cycle=%0d actual=%h required=%h", k, a_if.readdata, 32'hA0000000 + (k - 2) / 2); end
            end
            if (k >= 3 && k % 2 == 1) begin
                checks++;
                if (b_if.readdata !== 32'hB0000000 + (k - 3) / 2) begin errors++; $display("FAIL b2b_b_data cycle=%0d actual=%h required=%h", k, b_if.readdata, 32'hB0000000 + (k - 3) / 2); end
            end
            @(posedge clk); #1;
            if (k < 8 && k % 2 == 0) begin
                a_idx++;
                if (a_idx == 4) a_if.read = 0; else a_if.address = 15'h0040 + 15'(a_idx);
            end
            if (k < 8 && k % 2 == 1) begin
                b_idx++;
                if (b_idx == 4) b_if.read = 0; else b_if.address = 15'h0050 + 15'(b_idx);
            end
        end
    endtask

    task automatic test_byteenable();
        logic [31:0] d; int lat; bit stray;
        issue(1'b0, 1'b1, 15'h0060, 32'h11223344, 4'hF);
        issue(1'b0, 1'b1, 15'h0060, 32'hAABBCCDD, 4'h5);
        do_read(1'b0, 15'h0060, d, lat, stray);
        checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge actual=%h required=11bb33dd", d); end
    endtask

    task automatic test_range();
        logic [31:0] d; int lat; bit stray;
        b_if.address = 15'd25000; b_if.writedata = 32'h12345678; b_if.byteenable = 4'hF; b_if.write = 1;
        @(negedge clk);
        checks++; if (b_if.waitrequest !== 1'b0) begin errors++; $display("FAIL oor_accept actual=%b required=0", b_if.waitrequest); end
        checks++; if ({mem_chipselect, mem_write} !== 2'b00) begin errors++; $display("FAIL oor_cs actual=%b%b required=00", mem_chipselect, mem_write); end
        @(posedge clk); #1; b_if.write = 0;
        checks++; if (range_err !== 1'b1 || range_err_addr !== 15'd25000) begin errors++; $display("FAIL oor_capture actual=%b/%0d required=1/25000", range_err, range_err_addr); end
        do_read(1'b1, 15'd25000, d, lat, stray);
        checks++; if (d !== 32'h0 || lat != 2) begin errors++; $display("FAIL oor_read actual=%h lat%0d required=0 lat2", d, lat); end
        issue(1'b0, 1'b1, 15'd30000, 32'h0, 4'hF);
        checks++; if (range_err !== 1'b1 || range_err_addr !== 15'd25000) begin errors++; $display("FAIL oor_sticky actual=%b/%0d required=1/25000", range_err, range_err_addr); end
    endtask

    task automatic test_reset_mid_read();
        bit seen = 0;
        issue(1'b0, 1'b0, 15'h0040, 32'h0, 4'hF);
        reset = 1;
        @(negedge clk);
        checks++; if ({a_if.waitrequest, b_if.waitrequest} !== 2'b11 || {a_if.readdatavalid, b_if.readdatavalid} !== 2'b00) begin errors++; $display("FAIL midrst_ports actual=w%b%b v%b%b required=w11 v00", a_if.waitrequest, b_if.waitrequest, a_if.readdatavalid, b_if.readdatavalid); end
        checks++; if (a_if.readdata !== 32'h0 || b_if.readdata !== 32'h0 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL midrst_data actual=%h/%h cs%b required=0/0 cs0", a_if.readdata, b_if.readdata, mem_chipselect); end
        checks++; if (range_err !== 1'b0 || range_err_addr !== 15'h0 || mem_reset_req !== 1'b1) begin errors++; $display("FAIL midrst_err actual=%b/%0d req%b required=0/0 req1", range_err, range_err_addr, mem_reset_req); end
        @(posedge clk); #1; reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_if.readdatavalid || b_if.readdatavalid) seen = 1;
            @(posedge clk); #1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_rdv actual=1 required=0"); end
    endtask

    task automatic test_contention();
        logic [31:0] d; int lat; bit stray;
        issue(1'b0, 1'b1, 15'h0070, 32'h00000055, 4'hF);
        // rr_last is now A: B must be served first.
        a_if.address = 15'h0071; a_if.writedata = 32'hCAFEF00D; a_if.byteenable = 4'hF; a_if.write = 1;
        b_if.address = 15'h0070; b_if.read = 1;
        @(negedge clk);
        checks++; if ({a_if.waitrequest, b_if.waitrequest} !== 2'b10 || mem_write !== 1'b0 || mem_address !== 15'h0070) begin errors++; $display("FAIL cont_first actual=w%b%b we%b addr%h required=w10 we0 addr0070", a_if.waitrequest, b_if.waitrequest, mem_write, mem_address); end
        @(posedge clk); #1; b_if.read = 0;
        @(negedge clk);
        checks++; if (a_if.waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_address !== 15'h0071) begin errors++; $display("FAIL cont_second actual=wa%b we%b addr%h required=wa0 we1 addr0071", a_if.waitrequest, mem_write, mem_address); end
        @(posedge clk); #1; a_if.write = 0;
        @(negedge clk);
        checks++; if (b_if.readdatavalid !== 1'b1 || b_if.readdata !== 32'h00000055 || a_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL cont_resp actual=vb%b %h va%b required=vb1 00000055 va0", b_if.readdatavalid, b_if.readdata, a_if.readdatavalid); end
        @(posedge clk); #1;
        do_read(1'b1, 15'h0071, d, lat, stray);
        checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL cont_wdata actual=%h required=cafef00d", d); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_byteenable();
        test_range();
        test_reset_mid_read();
        test_contention();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
